// File: rtl/dvg_sequencer.sv
// dvg_sequencer: walks the DVG display list byte-by-byte, runs JSRL/RTSL/JMPL/HALT
// internally and hands VCTR/LABS/SVEC to the beam generator over valid/ready.
module dvg_sequencer #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [11:0] START_PC   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        mem_rd,
  output logic [12:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_op,
  output logic [15:0] cmd_w0,
  output logic [15:0] cmd_w1,
  output logic        busy,
  output logic        halted,
  output logic        error
);
  localparam logic [2:0] IDLE = 3'd0, FETCH0 = 3'd1, FETCH1 = 3'd2, EMIT = 3'd3, HALTED = 3'd4;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = $clog2(STACK_DEPTH);
  logic [2:0]     state_q, state_d;
  logic [11:0]    pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d, spm1;
  logic [11:0]    stk_q [STACK_DEPTH];
  logic           rd_q, rd_d, dv_q, dv_d;
  logic [12:0]    addr_q, addr_d;
  logic [2:0]     iss_q, iss_d;
  logic [1:0]     cap_q, cap_d;
  logic [15:0]    w0_q, w0_d;
  logic [7:0]     lo_q, lo_d;
  logic           cv_q, cv_d;
  logic [3:0]     op_q, op_d;
  logic [15:0]    cw0_q, cw0_d, cw1_q, cw1_d;
  logic           halted_q, halted_d, error_q, error_d;
  logic [15:0]    iw0, iw1;
  logic [3:0]     op;
  logic           two, fin, full, push, start;
  // Byte 2 is requested before the opcode is known so a 2-word fetch has no bubble;
  // a 1-word instruction finishes on the edge that captures byte 1 and drops it.
  assign iw0  = (cap_q == 2'd1) ? {mem_data, w0_q[7:0]} : w0_q;
  assign iw1  = {mem_data, lo_q};
  assign op   = iw0[15:12];
  assign two  = op <= 4'hA;
  assign fin  = dv_q && ((state_q == FETCH0 && cap_q == 2'd1 && !two) || (state_q == FETCH1 && cap_q == 2'd3));
  assign full = sp_q == SPW'(STACK_DEPTH);
  assign spm1 = sp_q - SPW'(1);
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    iss_d    = iss_q;
    dv_d     = 1'b0;
    cap_d    = cap_q;
    w0_d     = w0_q;
    lo_d     = lo_q;
    cv_d     = cv_q;
    op_d     = op_q;
    cw0_d    = cw0_q;
    cw1_d    = cw1_q;
    halted_d = halted_q;
    error_d  = error_q;
    push     = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE, HALTED: if (go) begin
        halted_d = 1'b0;
        error_d  = 1'b0;
        pc_d     = START_PC;
        sp_d     = '0;
        start    = 1'b1;
      end
      FETCH0, FETCH1: begin
        dv_d = rd_q;
        if (dv_q) begin
          cap_d   = cap_q + 2'd1;
          w0_d    = cap_q == 2'd0 ? {w0_q[15:8], mem_data} : cap_q == 2'd1 ? {mem_data, w0_q[7:0]} : w0_q;
          lo_d    = cap_q == 2'd2 ? mem_data : lo_q;
          state_d = (cap_q == 2'd1 && two) ? FETCH1 : state_q;
        end
        if (iss_q < 3'd4 && !fin) begin
          rd_d   = 1'b1;
          addr_d = {pc_q, 1'b0} + 13'(iss_q);
          iss_d  = iss_q + 3'd1;
        end
        if (fin) begin
          dv_d = 1'b0;
          if (two || op == 4'hF) begin
            cv_d    = 1'b1;
            op_d    = op;
            cw0_d   = iw0;
            cw1_d   = two ? iw1 : 16'h0;
            pc_d    = pc_q + (two ? 12'd2 : 12'd1);
            state_d = EMIT;
          end else if (op == 4'hB) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else if ((op == 4'hC && full) || (op == 4'hD && sp_q == '0)) begin
            error_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = HALTED;
          end else if (op == 4'hC) begin
            push  = 1'b1;
            sp_d  = sp_q + SPW'(1);
            pc_d  = iw0[11:0];
            start = 1'b1;
          end else if (op == 4'hD) begin
            sp_d  = spm1;
            pc_d  = stk_q[spm1[AW-1:0]];
            start = 1'b1;
          end else begin
            pc_d  = iw0[11:0];
            start = 1'b1;
          end
        end
      end
      EMIT: if (cmd_ready) begin
        cv_d  = 1'b0;
        start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = FETCH0;
      rd_d    = 1'b1;
      addr_d  = {pc_d, 1'b0};
      iss_d   = 3'd1;
      cap_d   = 2'd0;
      dv_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      sp_q     <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      iss_q    <= '0;
      dv_q     <= 1'b0;
      cap_q    <= '0;
      w0_q     <= '0;
      lo_q     <= '0;
      cv_q     <= 1'b0;
      op_q     <= '0;
      cw0_q    <= '0;
      cw1_q    <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      iss_q    <= iss_d;
      dv_q     <= dv_d;
      cap_q    <= cap_d;
      w0_q     <= w0_d;
      lo_q     <= lo_d;
      cv_q     <= cv_d;
      op_q     <= op_d;
      cw0_q    <= cw0_d;
      cw1_q    <= cw1_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      if (push) stk_q[sp_q[AW-1:0]] <= pc_q + 12'd1;
    end
  end
  assign mem_rd    = rd_q;
  assign mem_addr  = addr_q;
  assign cmd_valid = cv_q;
  assign cmd_op    = op_q;
  assign cmd_w0    = cw0_q;
  assign cmd_w1    = cw1_q;
  assign busy      = state_q == FETCH0 || state_q == FETCH1 || state_q == EMIT;
  assign halted    = halted_q;
  assign error     = error_q;
endmodule

// File: tb/tb_dvg_sequencer.sv
// tb_dvg_sequencer: directed display lists; expected commands go into a scoreboard
// queue that a negedge monitor drains on every accepted transfer.
module tb_dvg_sequencer;
  logic        clk = 1'b0, reset = 1'b1, go = 1'b0, cmd_ready = 1'b0;
  logic        mem_rd, cmd_valid, busy, halted, error;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_w0, cmd_w1;
  logic [7:0]  mem [8192];
  logic [35:0] exp_q [$];
  logic [12:0] alog [$];
  logic [35:0] hold, e;
  logic        hold_v = 1'b0;
  int          total = 0, bad = 0, ntx = 0;

  always #5 clk = ~clk;

  dvg_sequencer #(.STACK_DEPTH(4), .START_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .go(go), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_w0(cmd_w0), .cmd_w1(cmd_w1), .busy(busy), .halted(halted), .error(error)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  always @(negedge clk) begin
    if (reset) hold_v = 1'b0;
    else begin
      if (cmd_valid && hold_v) begin
        total++;
        if ({cmd_op, cmd_w0, cmd_w1} !== hold) begin
          bad++;
          $display("FAIL cmd_stable got=%h want=%h", {cmd_op, cmd_w0, cmd_w1}, hold);
        end
      end
      if (cmd_valid && cmd_ready) begin
        ntx++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd got=%h want=none", {cmd_op, cmd_w0, cmd_w1});
        end else begin
          e = exp_q.pop_front();
          if ({cmd_op, cmd_w0, cmd_w1} !== e) begin
            bad++;
            $display("FAIL cmd got=%h want=%h", {cmd_op, cmd_w0, cmd_w1}, e);
          end
        end
      end
      hold_v = cmd_valid && !cmd_ready;
      hold   = {cmd_op, cmd_w0, cmd_w1};
      if (mem_rd) alog.push_back(mem_addr);
    end
  end

  task automatic chk(input string n, input logic [35:0] a, input logic [35:0] w);
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, w);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
  endtask

  task automatic ld(input logic [11:0] a, input logic [15:0] w);
    mem[{a, 1'b0}] = w[7:0];
    mem[{a, 1'b1}] = w[15:8];
  endtask

  task automatic pulse_go(input int n);
    go = 1'b1;
    repeat (n) tick();
    go = 1'b0;
  endtask

  task automatic wait_halt(input string n);
    int k = 0;
    while (!halted && k < 300) begin
      tick();
      k++;
    end
    chk(n, halted, 1);
  endtask

  initial begin
    int n0, p, k;
    logic [12:0] e5 [4];
    e5[0] = 13'h1FFE; e5[1] = 13'h1FFF; e5[2] = 13'h0000; e5[3] = 13'h0001;
    clr();
    tick();
    tick();
    chk("rst_flags", {mem_rd, cmd_valid, busy, halted, error}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_cmd", {cmd_op, cmd_w0, cmd_w1}, 0);
    reset = 1'b0;
    tick();

    // SVEC then HALT, latency of a 1-word command
    ld(12'h000, 16'hF100);
    ld(12'h001, 16'hB000);
    cmd_ready = 1'b1;
    exp_q.push_back({4'hF, 16'hF100, 16'h0000});
    pulse_go(1);
    tick();
    tick();
    chk("t1_valid_e2", cmd_valid, 0);
    tick();
    chk("t1_valid_e3", cmd_valid, 1);
    wait_halt("t1_halt");
    chk("t1_idle", {busy, mem_rd, error}, 0);
    chk("t1_q", exp_q.size(), 0);

    // VCTR with backpressure, latency of a 2-word command
    clr();
    mem[0] = 8'h34; mem[1] = 8'h92; mem[2] = 8'h78; mem[3] = 8'h56;
    ld(12'h002, 16'hB000);
    cmd_ready = 1'b0;
    n0 = ntx;
    exp_q.push_back({4'h9, 16'h9234, 16'h5678});
    pulse_go(1);
    repeat (4) tick();
    chk("t2_valid_e4", cmd_valid, 0);
    tick();
    chk("t2_valid_e5", cmd_valid, 1);
    chk("t2_cmd", {cmd_op, cmd_w0, cmd_w1}, {4'h9, 16'h9234, 16'h5678});
    repeat (5) tick();
    chk("t2_stall", {cmd_valid, busy}, 2'b11);
    cmd_ready = 1'b1;
    wait_halt("t2_halt");
    chk("t2_ntx", ntx - n0, 1);
    chk("t2_q", exp_q.size(), 0);

    // JSRL / RTSL round trip
    clr();
    ld(12'h000, 16'hC010);
    ld(12'h001, 16'hB000);
    ld(12'h010, 16'hF0AA);
    ld(12'h011, 16'hD000);
    exp_q.push_back({4'hF, 16'hF0AA, 16'h0000});
    pulse_go(1);
    wait_halt("t3_halt");
    chk("t3_err", error, 0);
    chk("t3_pc", dut.pc_q, 12'h001);
    chk("t3_q", exp_q.size(), 0);

    // stack overflow on the fifth nested call
    clr();
    for (int i = 0; i < 5; i++) ld(12'(i), 16'hC000 | 16'(i + 1));
    pulse_go(1);
    wait_halt("t4_halt");
    chk("t4_err", error, 1);
    chk("t4_idle", {busy, mem_rd}, 0);
    // underflow on RTSL with an empty stack
    clr();
    ld(12'h000, 16'hD000);
    pulse_go(1);
    chk("t4b_clear", {halted, error}, 0);
    wait_halt("t4b_halt");
    chk("t4b_err", error, 1);

    // jump to the last word, VCTR wraps into word 0
    clr();
    ld(12'h000, 16'hEFFF);
    ld(12'h001, 16'hB000);
    ld(12'hFFF, 16'h1234);
    alog.delete();
    exp_q.push_back({4'h1, 16'h1234, 16'hEFFF});
    pulse_go(1);
    chk("t5_clear", {halted, error}, 0);
    wait_halt("t5_halt");
    chk("t5_q", exp_q.size(), 0);
    p = -1;
    for (int i = 0; i < alog.size(); i++) if (p < 0 && alog[i] == 13'h1FFE) p = i;
    chk("t5_found", p >= 0, 1);
    if (p >= 0 && p + 3 < alog.size())
      for (int j = 0; j < 4; j++) chk("t5_addr", alog[p + j], e5[j]);

    // asynchronous reset with a command pending
    clr();
    mem[0] = 8'h34; mem[1] = 8'h92; mem[2] = 8'h78; mem[3] = 8'h56;
    cmd_ready = 1'b0;
    pulse_go(1);
    k = 0;
    while (!cmd_valid && k < 50) begin
      tick();
      k++;
    end
    chk("t6_pending", cmd_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_flags", {mem_rd, cmd_valid, busy, halted, error}, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_cmd", {cmd_op, cmd_w0, cmd_w1}, 0);
    tick();
    reset = 1'b0;
    tick();
    // restart at word 0 while go is held through the busy cycles
    clr();
    ld(12'h000, 16'hF111);
    ld(12'h001, 16'hF222);
    ld(12'h002, 16'hB000);
    cmd_ready = 1'b1;
    exp_q.push_back({4'hF, 16'hF111, 16'h0000});
    exp_q.push_back({4'hF, 16'hF222, 16'h0000});
    pulse_go(4);
    wait_halt("t6_halt");
    chk("t6_q", exp_q.size(), 0);
    chk("t6_idle", {busy, error}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dvg_sequencer.md
Name: dvg_sequencer

Overview:
Instruction sequencer for the digital vector generator in the Asteroids system. On GODVG it walks the vector display list in vector memory over the byte-wide dvga/dvgd style read port, executing flow control internally (JSRL/RTSL/JMPL/HALT). It forwards each drawing command (VCTR, LABS, SVEC) over a valid/ready handshake to the downstream beam generator. It owns the vector-memory read port whenever it is busy.

Parameters:
STACK_DEPTH, 4, return-address stack entries for JSRL/RTSL (2..8)
START_PC, 0, 12-bit word address fetched after go

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
go  in  1  GODVG strobe; start display list at START_PC
mem_rd  out  1  read strobe to vector memory
mem_addr  out  13  byte address; {pc, byte_sel} plus word offset
mem_data  in  8  read data, valid the cycle after mem_rd (1-cycle sync RAM)
cmd_valid  out  1  drawing command available
cmd_ready  in  1  beam generator accepts command
cmd_op  out  4  opcode: 0-9 VCTR, A LABS, F SVEC
cmd_w0  out  16  first instruction word
cmd_w1  out  16  second word (VCTR/LABS); 0 for SVEC
busy  out  1  sequencer running (not IDLE/HALTED)
halted  out  1  HALT executed, or error; sticky until next go
error  out  1  stack overflow/underflow; sticky until next go

Behaviour:
- Reset, asynchronous: state IDLE. mem_rd=0, mem_addr=0, cmd_valid=0, cmd_op=0, cmd_w0=0, cmd_w1=0, busy=0, halted=0, error=0, pc=0, stack pointer=0.
- Words are little-endian. Low byte is at the even address and high byte at the odd address. Opcode = w0[15:12]. Jump target = w0[11:0], a word address.
- Instruction length: VCTR (0-9) and LABS (A) are 2 words. SVEC (F), HALT (B), JSRL (C), RTSL (D) and JMPL (E) are 1 word.
- States: IDLE -> FETCH0 -> (FETCH1 if 2-word) -> EXEC -> EMIT | FETCH0 | HALTED.
- go is sampled only in IDLE or HALTED. It clears halted and error, sets pc=START_PC and sp=0, and enters FETCH0. go while busy is ignored.
- Fetch: one byte read is issued per cycle, back-to-back. Read k of an instruction goes to byte address pc*2+k. Data is captured one cycle later.
  - Timing: if go is sampled at edge E0, a 1-word command has cmd_valid high after edge E3, and a 2-word command after edge E5.
  - Opcode is known after byte 1 is captured. A 2-word fetch continues seamlessly from that point, with no bubble.
- pc arithmetic is 12-bit modulo 4096. Wrap from 0xFFF to 0x000 is legal, including mid-instruction: the second word of a VCTR at 0xFFF comes from word 0x000.
- EXEC:
  - Drawing op: load cmd_*, assert cmd_valid, advance pc by the instruction length, go to EMIT.
  - JMPL: pc=target.
  - JSRL: push pc+1, then pc=target. Push when the stack is full sets error and halted and enters HALTED.
  - RTSL: pop into pc. Pop when the stack is empty sets error and halted and enters HALTED.
  - HALT: halted=1, enter HALTED. pc is unchanged.
  - Flow ops return to FETCH0 on the next cycle and emit nothing.
- EMIT:
  - cmd_* hold stable while cmd_valid=1 and cmd_ready=0.
  - When cmd_valid and cmd_ready are both high at an edge, the transfer completes. cmd_valid drops unless the next command is ready.
  - Prefetch of the next instruction is permitted during EMIT. cmd_* must not change until the transfer completes.
  - cmd_ready high while cmd_valid=0 has no effect.
- busy=1 in every state except IDLE and HALTED. mem_rd=0 whenever busy=0.
- mem_addr holds its last value when mem_rd=0.
- Reset asserted mid-operation aborts immediately. No partial command is left valid.
- Nested JSRL up to STACK_DEPTH levels is legal.

Test Plan:
- mem[0..1]=00 F1 (SVEC 0xF100), mem[2..3]=00 B0 (HALT); go pulse, cmd_ready=1 -> one command op=F w0=F100 w1=0, valid after 3rd edge; then halted=1, busy=0, mem_rd=0.
- VCTR at word 0: bytes 34 92 78 56, then HALT; cmd_ready held low 5 cycles -> op=9 w0=9234 w1=5678 stable throughout; exactly one transfer when ready rises.
- JSRL 0xC010 at word 0, subroutine at word 0x10 = SVEC 0xF0AA, RTSL, then HALT at word 1 -> commands F0AA only; final pc=1; error=0.
- Five nested JSRL with STACK_DEPTH=4 -> error=1, halted=1 on the fifth push; RTSL at word 0 with empty stack -> error=1.
- JMPL 0xEFFF at word 0, VCTR at words 0xFFF/0x000 -> mem_addr sequence 1FFE,1FFF,0000,0001; wrapped command emitted.
- Reset pulsed during EMIT with cmd_valid=1 -> all outputs 0 asynchronously; go afterwards restarts at word 0; go while busy ignored.
